ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
- AHB-side slave front end of the AHB-to-APB bridge. Sits directly downstream of the AHB master and feeds the APB controller FSM.
- Qualifies AHB transfers and decodes the peripheral select.
- Pipelines address, write data and direction two deep so the APB FSM can issue setup/enable phases.
- Runs a two-cycle ERROR response for unmapped addresses.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the bridge address window.
- SLOT_BITS, 26, log2 of each peripheral slot size (64 MB per slot).
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- Hclk  in  1  bridge clock; all state on rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Hwrite  in  1  AHB direction, 1=write.
- Hreadyin  in  1  AHB HREADY seen by the slave.
- Htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  in  32  AHB address (address phase).
- Hwdata  in  32  AHB write data (data phase).
- fsm_ready  in  1  ready from the downstream APB FSM.
- valid  out  1  qualified, mapped transfer this cycle.
- tempselx  out  3  one-hot peripheral select.
- Haddr1, Haddr2  out  32 each  address pipeline, stage 1 and stage 2.
- Hwdata1, Hwdata2  out  32 each  write-data pipeline, stage 1 and stage 2.
- Hwritereg, Hwritereg1  out  1 each  direction pipeline, stage 1 and stage 2.
- Hreadyout  out  1  HREADY driven back to the master.
- Hresp  out  2  AHB response: 00 OKAY, 01 ERROR.
- xfer_cnt  out  CNT_W  count of accepted transfers.

Behaviour:
- Reset (Hreset=1, asynchronous) clears all pipeline registers, xfer_cnt and the FSM (state=IDLE).
  - Combinational outputs then read: valid=0, Hresp=00, Hreadyout=fsm_ready.
  - Reset mid-transfer discards all pipeline contents. An in-progress ERROR sequence is aborted.
- active = Hreadyin & Htrans[1]. BUSY and IDLE never produce valid.
- mapped = Haddr within [BASE_ADDR, BASE_ADDR + 3·2^SLOT_BITS).
- slot = (Haddr − BASE_ADDR) >> SLOT_BITS.
- tempselx (combinational, from the current Haddr):
  - slot 0 → 3'b001, slot 1 → 3'b010, slot 2 → 3'b100.
  - Unmapped → 3'b000.
- valid (combinational) = active & mapped & (state==IDLE).
- Pipelines update on the rising edge only when Hreadyin=1; otherwise all six hold:
  - Haddr1<=Haddr; Haddr2<=Haddr1.
  - Hwdata1<=Hwdata; Hwdata2<=Hwdata1.
  - Hwritereg<=Hwrite; Hwritereg1<=Hwritereg.
- Latency: address appears on Haddr1 one cycle after its address phase. Its data appears on Hwdata1 one cycle after its data phase, i.e. two cycles after the address.
- xfer_cnt increments by 1 on every clock with valid=1 and wraps from all-ones to 0.
- Error FSM, states IDLE, ERR1, ERR2 (only with the macro below; otherwise always IDLE):
  - IDLE: if active & !mapped → ERR1, else stay. Outputs Hresp=00, Hreadyout=fsm_ready.
  - ERR1: Hresp=01, Hreadyout=0, unconditionally → ERR2.
  - ERR2: Hresp=01, Hreadyout=1, unconditionally → IDLE.
  - A transfer presented during ERR1/ERR2 is ignored: no valid, no count, no new error. The master must drive IDLE there per the AHB protocol.
- Simultaneous events:
  - An unmapped transfer in IDLE never asserts valid.
  - fsm_ready is ignored while in ERR1/ERR2.

Optional Feature:
- Macro AHB_DECODE_ERR_EN.
- Defined: the error FSM is implemented as above; unmapped active transfers receive the two-cycle ERROR response.
- Undefined: the FSM is removed. Hresp is tied to 00 and Hreadyout=fsm_ready. Unmapped transfers are silently dropped (valid=0, tempselx=000, no count).
- Pipelines behave identically in both builds.

Test Plan:
- Single write: Hwrite=1, Htrans=10, Hreadyin=1, Haddr=32'h8800_0001, then Htrans=00 with Hwdata=32'hA3.
  - Address cycle: valid=1, tempselx=100.
  - Next edge: Haddr1=8800_0001, Hwritereg=1.
  - Following edge: Hwdata1=A3, Haddr2=8800_0001.
  - xfer_cnt=1.
- Single read: Hwrite=0, Htrans=10, Haddr=32'h8000_00A2 → tempselx=001, valid=1 for one cycle, Hwritereg=0 after one edge, Hresp=00.
- Stall and non-active transfers: Hreadyin=0 with Htrans=10, Haddr=8400_0000 → valid=0, pipelines hold, count unchanged. Htrans=01 (BUSY) with Hreadyin=1 → valid=0.
- Unmapped address (macro defined): Htrans=10, Haddr=32'h9000_0000.
  - Next cycle: Hresp=01, Hreadyout=0. Then Hresp=01, Hreadyout=1. Then Hresp=00.
  - valid=0 throughout.
  - Macro undefined: Hresp stays 00.
- Counter wrap: 256 back-to-back SEQ transfers to 8000_0000 + 4n → xfer_cnt returns to 0, valid high every cycle.
- Reset mid-operation: assert Hreset during ERR1 and, separately, one cycle after a write address phase.
  - Immediately (asynchronous): Haddr1/2, Hwdata1/2, Hwritereg/1 and xfer_cnt are 0; Hresp=00; FSM in IDLE.
  - After release, the next transfer decodes normally.

Source files
------------

// File: rtl/ahb_slave_if_if.sv
// AHB-side bus bundle between the AHB master and the bridge slave front end.
// The master modport drives the address/data phase signals; the slave modport drives decode, pipeline and response.
interface ahb_slave_if_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic        Hwritereg;
  logic        Hwritereg1;
  logic        Hreadyout;
  logic [1:0]  Hresp;

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
    input  valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
           Hwritereg, Hwritereg1, Hreadyout, Hresp
  );

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
    output valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
           Hwritereg, Hwritereg1, Hreadyout, Hresp
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB slave front end of the AHB-to-APB bridge: qualifies and decodes transfers and pipelines them two deep.
// Define AHB_DECODE_ERR_EN to add the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          SLOT_BITS = 26,
  parameter int          CNT_W     = 8
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic             fsm_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  ahb_slave_if_if.slave    bus
);

  localparam logic [32:0] WINDOW = 33'(3) << SLOT_BITS;

  logic        active;
  logic        mapped;
  logic        in_idle;
  logic [32:0] offset;
  logic [31:0] slot_idx;

  logic [31:0]      haddr1_q, haddr1_d, haddr2_q, haddr2_d;
  logic [31:0]      hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
  logic             hwrite1_q, hwrite1_d, hwrite2_q, hwrite2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Addresses below the base wrap to a huge 33-bit offset, so one compare covers both window edges.
  assign active   = bus.Hreadyin & bus.Htrans[1];
  assign offset   = {1'b0, bus.Haddr} - {1'b0, BASE_ADDR};
  assign mapped   = (offset < WINDOW);
  assign slot_idx = offset[31:0] >> SLOT_BITS;

  always_comb begin
    bus.tempselx = 3'b000;
    if (mapped) begin
      case (slot_idx)
        32'd0:   bus.tempselx = 3'b001;
        32'd1:   bus.tempselx = 3'b010;
        32'd2:   bus.tempselx = 3'b100;
        default: bus.tempselx = 3'b000;
      endcase
    end
  end

  assign bus.valid = active & mapped & in_idle;

  always_comb begin
    haddr1_d  = haddr1_q;
    haddr2_d  = haddr2_q;
    hwdata1_d = hwdata1_q;
    hwdata2_d = hwdata2_q;
    hwrite1_d = hwrite1_q;
    hwrite2_d = hwrite2_q;
    if (bus.Hreadyin) begin
      haddr1_d  = bus.Haddr;
      haddr2_d  = haddr1_q;
      hwdata1_d = bus.Hwdata;
      hwdata2_d = hwdata1_q;
      hwrite1_d = bus.Hwrite;
      hwrite2_d = hwrite1_q;
    end
    cnt_d = bus.valid ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite1_q <= 1'b0;
      hwrite2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      haddr1_q  <= haddr1_d;
      haddr2_q  <= haddr2_d;
      hwdata1_q <= hwdata1_d;
      hwdata2_q <= hwdata2_d;
      hwrite1_q <= hwrite1_d;
      hwrite2_q <= hwrite2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.Haddr1     = haddr1_q;
  assign bus.Haddr2     = haddr2_q;
  assign bus.Hwdata1    = hwdata1_q;
  assign bus.Hwdata2    = hwdata2_q;
  assign bus.Hwritereg  = hwrite1_q;
  assign bus.Hwritereg1 = hwrite2_q;
  assign xfer_cnt       = cnt_q;

`ifdef AHB_DECODE_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t     state_q, state_d;
  logic [1:0] hresp_q, hresp_d;
  logic       err_ready_q, err_ready_d;

  // Response outputs are registered alongside the state so ERR1/ERR2 drive clean values off the flops.
  always_comb begin
    state_d     = state_q;
    hresp_d     = hresp_q;
    err_ready_d = err_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (active && !mapped) begin
          state_d     = ST_ERR1;
          hresp_d     = 2'b01;
          err_ready_d = 1'b0;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hresp_d     = 2'b01;
        err_ready_d = 1'b1;
      end
      ST_ERR2: begin
        state_d     = ST_IDLE;
        hresp_d     = 2'b00;
        err_ready_d = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        hresp_d     = 2'b00;
        err_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      hresp_q     <= 2'b00;
      err_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hresp_q     <= hresp_d;
      err_ready_q <= err_ready_d;
    end
  end

  assign in_idle       = (state_q == ST_IDLE);
  assign bus.Hresp     = hresp_q;
  assign bus.Hreadyout = in_idle ? fsm_ready : err_ready_q;
`else
  assign in_idle       = 1'b1;
  assign bus.Hresp     = 2'b00;
  assign bus.Hreadyout = fsm_ready;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Randomised self-checking bench for ahb_slave_if against a transfer-level reference model.
// Works in both builds; the model follows AHB_DECODE_ERR_EN.
module tb_ahb_slave_if;

`ifdef AHB_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam longint BASE = 64'h8000_0000;
  localparam longint SLOT = 64'h0400_0000;

  logic       Hclk = 1'b0;
  logic       Hreset = 1'b1;
  logic       fsm_ready = 1'b1;
  logic [7:0] xfer_cnt;

  ahb_slave_if_if bus ();

  ahb_slave_if #(.BASE_ADDR(32'h8000_0000), .SLOT_BITS(26), .CNT_W(8)) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .fsm_ready (fsm_ready),
    .xfer_cnt  (xfer_cnt),
    .bus       (bus.slave)
  );

  always #5 Hclk = ~Hclk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: last two captured beats, error phase (0 none, 1 first, 2 second), transfer count.
  logic [31:0] mAddr[2];
  logic [31:0] mData[2];
  logic        mWr[2];
  int          mErr;
  logic [7:0]  mCnt;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mAddr = '{32'h0, 32'h0};
    mData = '{32'h0, 32'h0};
    mWr   = '{1'b0, 1'b0};
    mErr  = 0;
    mCnt  = 8'h00;
  endtask

  task automatic checkRegistered();
    checkOutput("Haddr1", bus.Haddr1, mAddr[0]);
    checkOutput("Haddr2", bus.Haddr2, mAddr[1]);
    checkOutput("Hwdata1", bus.Hwdata1, mData[0]);
    checkOutput("Hwdata2", bus.Hwdata2, mData[1]);
    checkOutput("Hwritereg", bus.Hwritereg, mWr[0]);
    checkOutput("Hwritereg1", bus.Hwritereg1, mWr[1]);
    checkOutput("xfer_cnt", xfer_cnt, mCnt);
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance model, check flops after the edge.
  task automatic applyStimulus(input logic wr, input logic rdy, input logic [1:0] tr,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic frdy);
    bit     act, mapd, expValid;
    longint off;
    logic [2:0] expSel;
    @(negedge Hclk);
    bus.Hwrite   = wr;
    bus.Hreadyin = rdy;
    bus.Htrans   = tr;
    bus.Haddr    = addr;
    bus.Hwdata   = wdata;
    fsm_ready    = frdy;
    #1;
    act  = rdy && tr[1];
    off  = longint'(addr) - BASE;
    mapd = (off >= 0) && (off < 3 * SLOT);
    expSel   = mapd ? 3'(1 << (off / SLOT)) : 3'b000;
    expValid = act && mapd && (mErr == 0);
    checkOutput("valid", bus.valid, expValid);
    checkOutput("tempselx", bus.tempselx, expSel);
    checkOutput("Hresp", bus.Hresp, (mErr != 0) ? 2'b01 : 2'b00);
    checkOutput("Hreadyout", bus.Hreadyout, (mErr == 0) ? frdy : (mErr == 2));
    if (expValid) mCnt = mCnt + 8'd1;
    if (mErr == 1)      mErr = 2;
    else if (mErr == 2) mErr = 0;
    else if (ERR_EN && act && !mapd) mErr = 1;
    if (rdy) begin
      mAddr[1] = mAddr[0]; mAddr[0] = addr;
      mData[1] = mData[0]; mData[0] = wdata;
      mWr[1]   = mWr[0];   mWr[0]   = wr;
    end
    @(posedge Hclk);
    #1;
    checkRegistered();
  endtask

  // Asynchronous reset pulse inside the high clock phase, checked while still asserted.
  task automatic pulseReset();
    bus.Htrans = 2'b00;
    #1 Hreset = 1'b1;
    #1;
    modelReset();
    checkRegistered();
    checkOutput("rst_Hresp", bus.Hresp, 2'b00);
    checkOutput("rst_valid", bus.valid, 1'b0);
    checkOutput("rst_Hreadyout", bus.Hreadyout, fsm_ready);
    #1 Hreset = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0, 1, 2: randAddr = 32'(BASE + SLOT * $urandom_range(0, 2)) + ($urandom & 32'h03FF_FFFF);
      3:       randAddr = 32'h8000_0000 - 32'($urandom_range(1, 4096));
      4:       randAddr = 32'h8C00_0000 + ($urandom & 32'h00FF_FFFF);
      default: randAddr = $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] cntStart;
    bus.Hwrite   = 1'b0;
    bus.Hreadyin = 1'b1;
    bus.Htrans   = 2'b00;
    bus.Haddr    = 32'h0;
    bus.Hwdata   = 32'h0;
    modelReset();
    $display("[TB] start, decode error response %0s", ERR_EN ? "enabled" : "disabled");
    repeat (2) @(negedge Hclk);
    checkRegistered();
    checkOutput("init_Hresp", bus.Hresp, 2'b00);
    checkOutput("init_Hreadyout", bus.Hreadyout, 1'b1);
    Hreset = 1'b0;

    // Single write then its data phase.
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h8800_0001, 32'h0, 1'b1);
    checkOutput("wr_Haddr1", bus.Haddr1, 32'h8800_0001);
    checkOutput("wr_Hwritereg", bus.Hwritereg, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'hA3, 1'b1);
    checkOutput("wr_Hwdata1", bus.Hwdata1, 32'hA3);
    checkOutput("wr_Haddr2", bus.Haddr2, 32'h8800_0001);
    checkOutput("wr_cnt", xfer_cnt, 8'd1);

    // Single read, stall, BUSY.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h8000_00A2, 32'h0, 1'b1);
    checkOutput("rd_Hwritereg", bus.Hwritereg, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h8400_0000, 32'h55, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h8400_0000, 32'h66, 1'b1);
    checkOutput("busy_cnt", xfer_cnt, 8'd2);

    // Unmapped address followed by idle cycles.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1);

    // 256 back-to-back transfers wrap the counter.
    cntStart = mCnt;
    for (int n = 0; n < 256; n++)
      applyStimulus(1'b1, 1'b1, (n == 0) ? 2'b10 : 2'b11, 32'h8000_0000 + 32'(4 * n), $urandom, 1'b1);
    checkOutput("cnt_wrap", xfer_cnt, cntStart);

    // Reset during the error response, then a normal transfer.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'hF000_0000, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h8400_0010, 32'h0, 1'b1);
    checkOutput("post_rst_cnt", xfer_cnt, 8'd1);

    // Reset one cycle after a write address phase.
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h8000_0040, 32'h1234, 1'b1);
    pulseReset();
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h8800_0000, 32'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom), randAddr(),
                    $urandom, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
